fifo_wr_arbiter: RTL and testbench

//  Shares the write port of one fifo among N requesters with round-robin arbitration and packet locking.

---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the fifo write-port arbiter.
// Stats ports/counters exist only when FIFO_ARB_STATS_EN is defined.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int STATS_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first set req bit at or after start,
// wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N    = 2,
  parameter int LOGN = 1
) (
  input  logic [N-1:0]    req,
  input  logic [LOGN-1:0] start,
  output logic            valid,
  output logic [LOGN-1:0] idx
);

  int k;

  // Scan from the far end so the closest hit to start wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    k     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(start) + i;
      if (k >= N) k = k - N;
      if (req[k]) begin
        valid = 1'b1;
        idx   = LOGN'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter for one fifo write port.
// Define FIFO_ARB_STATS_EN to add o_words/o_stall counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int W    = 8,
  parameter int N    = 2,
  parameter int LOGN = 1
) (
  input  logic            clk,
  input  logic            i_reset,
  input  logic [N-1:0]    i_req,
  input  logic [N-1:0]    i_last,
  input  logic [N*W-1:0]  i_data,
  output logic [N-1:0]    o_ack,
  input  logic            i_fifo_full,
  output logic            o_fifo_wr,
  output logic [W-1:0]    o_fifo_data,
  output logic            o_busy,
  output logic [LOGN-1:0] o_owner
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N*STATS_W-1:0] o_words,
  output logic [STATS_W-1:0]   o_stall
`endif
);

  arb_state_t      state_q, state_d;
  logic [LOGN-1:0] ptr_q, ptr_d;
  logic [LOGN-1:0] owner_q, owner_d;
  logic            pick_valid;
  logic [LOGN-1:0] pick_idx;

  function automatic logic [LOGN-1:0] nxt(input logic [LOGN-1:0] k);
    if (int'(k) >= N - 1) return '0;
    return k + LOGN'(1);
  endfunction

  rr_pick #(
    .N    (N),
    .LOGN (LOGN)
  ) u_pick (
    .req   (i_req),
    .start (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // A full fifo freezes everything: no ack, no state movement.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    o_ack   = '0;
    if (!i_reset && !i_fifo_full) begin
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            o_ack[pick_idx] = 1'b1;
            owner_d         = pick_idx;
            if (i_last[pick_idx]) ptr_d = nxt(pick_idx);
            else state_d = LOCK;
          end
        end
        LOCK: begin
          if (i_req[owner_q]) begin
            o_ack[owner_q] = 1'b1;
            if (i_last[owner_q]) begin
              state_d = IDLE;
              ptr_d   = nxt(owner_q);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    o_fifo_data = '0;
    for (int k = 0; k < N; k++)
      if (o_ack[k]) o_fifo_data = i_data[k*W +: W];
  end

  assign o_fifo_wr = |o_ack;
  assign o_busy    = (state_q == LOCK);
  assign o_owner   = owner_q;

`ifdef FIFO_ARB_STATS_EN
  logic [N*STATS_W-1:0] words_q;
  logic [STATS_W-1:0]   stall_q;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      for (int k = 0; k < N; k++)
        if (o_ack[k])
          words_q[k*STATS_W +: STATS_W] <=
            words_q[k*STATS_W +: STATS_W] + STATS_W'(1);
      if (|i_req && i_fifo_full && stall_q != '1)
        stall_q <= stall_q + STATS_W'(1);
    end
  end

  assign o_words = words_q;
  assign o_stall = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed vector table plus randomized run against a reference model.
module tb_fifo_wr_arbiter;

  localparam int W    = 8;
  localparam int N    = 2;
  localparam int LOGN = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, last, ack;
  logic [N*W-1:0]  data;
  logic            full, wr, busy;
  logic [W-1:0]    fdata;
  logic [LOGN-1:0] owner;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] words;
  logic [15:0]     stall;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.W(W), .N(N), .LOGN(LOGN)) dut (
    .clk         (clk),
    .i_reset     (rst),
    .i_req       (req),
    .i_last      (last),
    .i_data      (data),
    .o_ack       (ack),
    .i_fifo_full (full),
    .o_fifo_wr   (wr),
    .o_fifo_data (fdata),
    .o_busy      (busy),
    .o_owner     (owner)
`ifdef FIFO_ARB_STATS_EN
    ,
    .o_words     (words),
    .o_stall     (stall)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [1:0] last;
    logic       full;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] ack;
    logic [7:0] dat;
    logic       busy;
    logic       own;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(
    input logic r, input logic [1:0] q, input logic [1:0] l,
    input logic f, input logic [7:0] a, input logic [7:0] b,
    input logic [1:0] ea, input logic [7:0] ed,
    input logic eb, input logic eo);
    vec_t v;
    v.rst = r; v.req = q; v.last = l; v.full = f;
    v.d0 = a; v.d1 = b; v.ack = ea; v.dat = ed;
    v.busy = eb; v.own = eo;
    return v;
  endfunction

  // reference model state (spec level)
  int m_lock;   // -1 when no packet is open
  int m_start;
  int m_own;
  int open_pkt;

  initial begin
    logic [N-1:0] eack;
    logic [W-1:0] edat;
    int src;

    //              rst req   last  full d0     d1     ack   dat    bsy own
    tbl[0]  = mk(1, 2'b00, 2'b00, 0, 8'h00, 8'h00, 2'b00, 8'h00, 0, 0);
    tbl[1]  = mk(0, 2'b11, 2'b11, 0, 8'hA0, 8'hB0, 2'b01, 8'hA0, 0, 0);
    tbl[2]  = mk(0, 2'b11, 2'b11, 0, 8'hA0, 8'hB0, 2'b10, 8'hB0, 0, 1);
    tbl[3]  = mk(0, 2'b11, 2'b11, 0, 8'hA0, 8'hB0, 2'b01, 8'hA0, 0, 0);
    tbl[4]  = mk(0, 2'b11, 2'b11, 0, 8'hA0, 8'hB0, 2'b10, 8'hB0, 0, 1);
    tbl[5]  = mk(0, 2'b11, 2'b00, 0, 8'hC1, 8'hD1, 2'b01, 8'hC1, 1, 0);
    tbl[6]  = mk(0, 2'b11, 2'b00, 0, 8'hC2, 8'hD1, 2'b01, 8'hC2, 1, 0);
    tbl[7]  = mk(0, 2'b11, 2'b01, 0, 8'hC3, 8'hD1, 2'b01, 8'hC3, 0, 0);
    tbl[8]  = mk(0, 2'b10, 2'b10, 0, 8'h00, 8'hD1, 2'b10, 8'hD1, 0, 1);
    for (int i = 9; i < 14; i++)
      tbl[i] = mk(0, 2'b01, 2'b01, 1, 8'hA5, 8'h00, 2'b00, 8'h00, 0, 1);
    tbl[14] = mk(0, 2'b01, 2'b01, 0, 8'hA5, 8'h00, 2'b01, 8'hA5, 0, 0);
    tbl[15] = mk(0, 2'b10, 2'b00, 0, 8'h77, 8'hE1, 2'b10, 8'hE1, 1, 1);
    for (int i = 16; i < 19; i++)
      tbl[i] = mk(0, 2'b01, 2'b01, 0, 8'h77, 8'h00, 2'b00, 8'h00, 1, 1);
    tbl[19] = mk(0, 2'b11, 2'b11, 0, 8'h77, 8'hE2, 2'b10, 8'hE2, 0, 1);
    tbl[20] = mk(0, 2'b01, 2'b01, 0, 8'h77, 8'h00, 2'b01, 8'h77, 0, 0);
    tbl[21] = mk(0, 2'b10, 2'b00, 0, 8'h00, 8'hF1, 2'b10, 8'hF1, 1, 1);
    tbl[22] = mk(1, 2'b10, 2'b00, 0, 8'h00, 8'hF2, 2'b00, 8'h00, 0, 0);
    tbl[23] = mk(0, 2'b11, 2'b11, 0, 8'hA0, 8'hB0, 2'b01, 8'hA0, 0, 0);
    tbl[24] = mk(0, 2'b11, 2'b11, 0, 8'hA0, 8'hB0, 2'b10, 8'hB0, 0, 1);

    rst = 1'b1; req = '0; last = '0; data = '0; full = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 25; i++) begin
      rst  = tbl[i].rst;
      req  = tbl[i].req;
      last = tbl[i].last;
      full = tbl[i].full;
      data = {tbl[i].d1, tbl[i].d0};
      #1;
      chk($sformatf("v%0d ack", i), 32'(ack), 32'(tbl[i].ack));
      chk($sformatf("v%0d wr", i), 32'(wr), 32'(|tbl[i].ack));
      chk($sformatf("v%0d data", i), 32'(fdata), 32'(tbl[i].dat));
      @(posedge clk); #1;
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d owner", i), 32'(owner), 32'(tbl[i].own));
    end

    // randomized run
    rst = 1'b1; req = '0; last = '0; full = 1'b0;
    m_lock = -1; m_start = 0; m_own = 0; open_pkt = -1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(49) == 0);
      full = ($urandom_range(4) == 0);
      #1;
      eack = '0;
      edat = '0;
      if (rst) begin
        m_lock = -1; m_start = 0; m_own = 0;
      end else if (!full) begin
        if (m_lock >= 0) begin
          if (req[m_lock]) begin
            eack[m_lock] = 1'b1;
            edat = data[m_lock*W +: W];
            if (last[m_lock]) begin
              m_start = (m_lock + 1) % N;
              m_lock  = -1;
            end
          end
        end else begin
          for (int off = 0; off < N; off++) begin
            int k;
            k = (m_start + off) % N;
            if (eack == '0 && req[k]) begin
              eack[k] = 1'b1;
              edat = data[k*W +: W];
              m_own = k;
              if (last[k]) m_start = (k + 1) % N;
              else m_lock = k;
            end
          end
        end
      end
      chk("rnd ack", 32'(ack), 32'(eack));
      chk("rnd wr", 32'(wr), 32'(eack != '0));
      chk("rnd data", 32'(fdata), 32'(edat));
      chk("rnd onehot", 32'($onehot0(ack)), 32'd1);
      if (full) chk("rnd ack_full", 32'(ack), 32'd0);
      if (rst) open_pkt = -1;
      else if (wr) begin
        src = 0;
        for (int k = 0; k < N; k++) if (ack[k]) src = k;
        if (open_pkt >= 0) chk("rnd contig", 32'(src), 32'(open_pkt));
        open_pkt = last[src] ? -1 : src;
      end
      @(posedge clk); #1;
      chk("rnd busy", 32'(busy), 32'(m_lock >= 0));
      chk("rnd owner", 32'(owner), 32'(m_own));
      for (int k = 0; k < N; k++) begin
        if (req[k] && eack[k]) begin
          req[k]  = ($urandom_range(3) != 0);
          last[k] = ($urandom_range(2) == 0);
          data[k*W +: W] = W'($urandom);
        end else if (!req[k] && $urandom_range(1) == 1) begin
          req[k]  = 1'b1;
          last[k] = ($urandom_range(2) == 0);
          data[k*W +: W] = W'($urandom);
        end
      end
    end

`ifdef FIFO_ARB_STATS_EN
    rst = 1'b1; full = 1'b0; req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    req = 2'b01; last = 2'b01;
    repeat (10) @(posedge clk);
    #1; req = 2'b10; last = 2'b10;
    repeat (4) @(posedge clk);
    #1; req = 2'b01; full = 1'b1;
    repeat (7) @(posedge clk);
    #1; req = '0; full = 1'b0;
    chk("stats words", words, {16'd4, 16'd10});
    chk("stats stall", 32'(stall), 32'd7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
